// File: rtl/ram_fifo_pkg.sv
// Shared types and default sizes for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND  = 2'd1,
    OUT_FULL = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Runs a single-port RAM as a FIFO with a one-word output register.
// Reads take priority over writes on the shared RAM port.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  fifo_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              has_words;
  logic              rd_go;
  logic              wr_go;

  always_comb begin
    has_words = (count_q != '0);
    case (state_q)
      IDLE:     rd_go = has_words;
      OUT_FULL: rd_go = has_words && out_ready;
      default:  rd_go = 1'b0;
    endcase
    in_ready = (count_q < DEPTH) && !rd_go;
    wr_go    = in_valid && in_ready;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    ram_w       = 1'b0;
    ram_address = rd_ptr_q;
    ram_d_in    = in_data;

    if (rd_go) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W + 1)'(1);
    end else if (wr_go) begin
      // Reset can coincide with a handshake; keep the RAM untouched then.
      ram_w       = !rst;
      ram_address = wr_ptr_q;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      count_d     = count_q + (ADDR_W + 1)'(1);
    end else begin
      ram_address = rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (rd_go) state_d = RD_PEND;
        else       state_d = IDLE;
      end
      RD_PEND: begin
        out_data_d = ram_out;
        state_d    = OUT_FULL;
      end
      OUT_FULL: begin
        if (rd_go)          state_d = RD_PEND;
        else if (out_ready) state_d = IDLE;
        else                state_d = OUT_FULL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = out_data_q;
  assign level     = count_q;
  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural RAM and a data scoreboard.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [5:0] level;
  logic       full;
  logic       empty;
  logic [7:0] ram_d_in;
  logic [4:0] ram_address;
  logic       ram_w;
  logic [7:0] ram_out = 8'h00;

  logic [7:0] mem [32];
  logic [7:0] sb [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty),
    .ram_d_in(ram_d_in), .ram_address(ram_address), .ram_w(ram_w),
    .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: write on w, otherwise registered read.
  always @(posedge clk) begin
    if (ram_w) mem[ram_address] <= ram_d_in;
    else       ram_out <= mem[ram_address];
  end

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got %h, required no word", out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin
            n_fail++;
            $display("FAIL sb_data: got %h, required %h", out_data, exp_w);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    check("rst_ram_w", ram_w, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    step();
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] a);
    int k = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else begin
      check("send_ram_w", ram_w, 1);
      check("send_addr", ram_address, a);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!empty && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", empty, 1);
    check("drain_sb_left", sb.size(), 0);
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int last_cyc;
    int k;
    logic [7:0] w;

    // Single word: latency and level 0->1->0.
    do_reset();
    in_valid = 1'b1; in_data = 8'h10;
    @(negedge clk);
    check("t1_ram_w", ram_w, 1);
    check("t1_addr", ram_address, 0);
    check("t1_level0", level, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t1_level1", level, 1);
    check("t1_rdgo_blocks", in_ready, 0);
    step();
    @(negedge clk);
    check("t1_level_back0", level, 0);
    check("t1_not_valid_yet", out_valid, 0);
    step(); out_ready = 1'b1;
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 32'h10);
    step(); out_ready = 1'b0;
    @(negedge clk);
    check("t1_empty", empty, 1);
    step();

    // Three writes with the consumer stalled.
    do_reset();
    send(8'h10, 5'd0);
    send(8'h11, 5'd1);
    send(8'haf, 5'd2);
    @(negedge clk);
    check("t2_level", level, 2);
    check("t2_head_valid", out_valid, 1);
    check("t2_head", out_data, 32'h10);
    step();
    drain();

    // Fill: word 0 in the output register, 32 in RAM.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      w = 8'(i);
      send(w, w[4:0]);
    end
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("t3_full", full, 1);
    check("t3_in_ready", in_ready, 0);
    check("t3_level", level, 32);
    check("t3_head", out_data, 0);
    check("t3_head_valid", out_valid, 1);
    step(); in_valid = 1'b0;

    // Drain the full FIFO, one word every two cycles.
    out_ready = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 33; i++) begin
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!out_valid) check("t4_timeout", 0, 1);
      else if (i > 0) check("t4_gap", cyc - last_cyc, 2);
      last_cyc = cyc;
    end
    step(); out_ready = 1'b0;
    @(negedge clk);
    check("t4_empty", empty, 1);
    check("t4_sb_left", sb.size(), 0);
    step();

    // Simultaneous push and pop: the read wins the port.
    do_reset();
    send(8'h01, 5'd0);
    send(8'h02, 5'd1);
    send(8'h03, 5'd2);
    in_valid = 1'b1; in_data = 8'h04; out_ready = 1'b1;
    @(negedge clk);
    check("t5_in_ready", in_ready, 0);
    check("t5_ram_w", ram_w, 0);
    check("t5_rd_addr", ram_address, 1);
    step(); out_ready = 1'b0;
    @(negedge clk);
    check("t5_late_ready", in_ready, 1);
    check("t5_late_w", ram_w, 1);
    check("t5_late_addr", ram_address, 3);
    step(); in_valid = 1'b0;
    drain();

    // Reset while a read is pending with five words in RAM.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      w = 8'h20 + 8'(i);
      send(w, 5'(i));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_level6", level, 6);
    step();
    out_ready = 1'b0; rst = 1'b1; in_valid = 1'b1; in_data = 8'hee;
    @(negedge clk);
    check("t6_level5", level, 5);
    check("t6_pending", out_valid, 0);
    check("t6_not_empty", empty, 0);
    step();
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_level", level, 0);
    check("t6_empty", empty, 1);
    check("t6_ram_w", ram_w, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Controller that runs the single-port 32x8 `ram` block as a 32-deep FIFO. It sits directly upstream of `ram`, and owns the RAM's `d_in`, `address` and `w`. It consumes the RAM's `out` and presents it to a downstream consumer through a one-word output register. Both producer and consumer use valid/ready handshakes.

## Interface
- `DATA_W`, default 8: word width; matches `ram`.
- `ADDR_W`, default 5: RAM address width; depth is `DEPTH = 2**ADDR_W` = 32.
- Clocking (already decided): one clock, `clk`. Reset is `rst`, synchronous and active-high.
- `clk` input, 1: sole clock. All state changes on its rising edge.
- `rst` input, 1: synchronous active-high reset.
- `in_valid` input, 1: producer has a word.
- `in_ready` output, 1: controller accepts the word this cycle.
- `in_data` input, `DATA_W`: producer word.
- `out_valid` output, 1: `out_data` holds a word.
- `out_ready` input, 1: consumer takes the word this cycle.
- `out_data` output, `DATA_W`: head-of-FIFO word.
- `level` output, `ADDR_W+1`: number of words held in the RAM. Excludes the output register and any read in flight.
- `full` output, 1: `level == DEPTH`.
- `empty` output, 1: no words anywhere. That means `level == 0`, `out_valid == 0`, and no read pending.
- `ram_d_in` output, `DATA_W`: to `ram.d_in`.
- `ram_address` output, `ADDR_W`: to `ram.address`.
- `ram_w` output, 1: to `ram.w`; 1 = write.
- `ram_out` input, `DATA_W`: from `ram.out`.

## Operation
- RAM contract:
  - Write: `ram` writes `d_in` to `address` on the rising edge when `w = 1`.
  - Read: with `w = 0`, `out` shows `mem[address]` after that rising edge, so it is valid for the whole next cycle.
- Registers:
  - `wr_ptr` and `rd_ptr`, each `ADDR_W` bits. Both wrap from 31 to 0 by natural overflow.
  - `count`, `ADDR_W+1` bits; drives `level`.
  - FSM state.
  - `out_data` register.
- FSM states:
  - `IDLE`: output register empty, nothing in flight.
  - `RD_PEND`: a read was issued last cycle.
  - `OUT_FULL`: `out_valid = 1`.
- Read issue (`rd_go`) in cycle N. It fires when either:
  - state is `IDLE` and `count > 0`, or
  - state is `OUT_FULL`, `out_ready = 1` and `count > 0`.
- When `rd_go` fires:
  - `ram_w = 0`, `ram_address = rd_ptr`.
  - `rd_ptr` is incremented and `count` decremented.
  - Next state is `RD_PEND`.
- `RD_PEND`: capture `ram_out` into `out_data`, then go to `OUT_FULL`.
- `OUT_FULL` with `out_ready = 1` and `count == 0`: go to `IDLE`.
- `OUT_FULL` with `out_ready = 0`: hold state and `out_data`.
- Write:
  - `in_ready = (count < DEPTH) && !rd_go`. Reads have priority on the single port.
  - On `in_valid && in_ready`: `ram_w = 1`, `ram_address = wr_ptr`, `ram_d_in = in_data`. Then `wr_ptr` is incremented and `count` incremented.
- Writes are allowed in every state, including `RD_PEND`.
- Reads and writes are mutually exclusive per cycle, so `count` changes by at most ±1.
- When neither a read nor a write fires: `ram_w = 0`, `ram_address = rd_ptr`, `ram_d_in = in_data`.
- `ram_*` outputs are combinational from state and pointers. `in_ready` is combinational from `count`, state and `out_ready`.

## Timing
- Reset: state `IDLE`, both pointers 0, `count` 0, `out_data` 0.
  - Resulting outputs: `out_valid` 0, `in_ready` 1, `full` 0, `empty` 1, `level` 0.
  - `ram_w` is forced to 0 while `rst` is high.
- Reset mid-operation: all in-flight and stored words are discarded on the next edge. RAM contents are not cleared and are don't-care.
- Write-to-output latency into an empty FIFO:
  - Write handshake in cycle N.
  - `rd_go` in cycle N+1.
  - Capture at the end of N+2.
  - `out_valid` high in N+3.
- Sustained drain: one word per 2 cycles. Pop in cycle N gives the next `out_valid` in N+2.
- Full: `in_ready = 0` when `count == 32`, regardless of `in_valid`. A word in the output register does not count toward `full`.
- `in_valid` held high while `rd_go` fires: no write that cycle. The write completes on the next cycle with room.
- `out_ready` while `out_valid = 0` is ignored.

## Structure
- Package `ram_fifo_pkg` holds:
  - the FSM state enum `fifo_state_t` (`IDLE`, `RD_PEND`, `OUT_FULL`);
  - default `DATA_W` and `ADDR_W` localparams.
- No sub-module. `ram` is instantiated beside this block by the enclosing wrapper `ram_fifo_top`, which wires the `ram_*` ports.

## Test plan
- Reset, then one write of `in_data = 8'h10`:
  - `ram_w = 1` at address 0;
  - `out_valid` rises 3 cycles after the handshake with `out_data = 8'h10`;
  - `level` goes 0→1→0.
- Write `8'h10`, `8'h11`, `8'haf` back-to-back with `out_ready = 0`:
  - write addresses 0, 1, 2;
  - head `8'h10` held;
  - `level` = 2 once the first read completes.
- Write 33 words (`8'h00`–`8'h20`), consumer stalled from the start:
  - word 0 sits in the output register;
  - words 1–32 fill the RAM;
  - `full` = 1 and `in_ready` = 0.
- Continue from the full FIFO with `out_ready = 1`:
  - all 33 words arrive in order, one per 2 cycles;
  - wr/rd pointers wrap 31→0 correctly;
  - `empty` = 1 at the end.
- With `count > 0` and `OUT_FULL`, assert `in_valid` and `out_ready` together:
  - read wins, `in_ready` = 0 that cycle;
  - the write lands on the following cycle.
- Assert `rst` while in `RD_PEND` with `level` = 5:
  - next cycle `out_valid` = 0, `level` = 0, `empty` = 1, `ram_w` = 0.
